// File: rtl/mem_burst_resp_pkg.sv
// Shared types and helpers for the mem_burst_resp burst responder.
package mem_burst_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdData
  } state_e;

  // Read return FIFO depth; also the cap on reads outstanding (FIFO + in flight).
  localparam int unsigned FIFO_DEPTH = 2;

  // log2 of the beat size in bytes.
  function automatic int unsigned byte_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  // Number of beats in a burst of len bytes; partial beats are dropped, minimum one beat.
  function automatic logic [31:0] beats_from_len(input logic [31:0] len,
                                                 input int unsigned data_width);
    logic [31:0] n;
    n = len >> byte_shift(data_width);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/mem_burst_resp_if.sv
// Burst read/write channel bundle between the fetch controller (master) and the
// memory-side responder (slave).
interface mem_burst_resp_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) ();

  logic                  wr_req;
  logic                  wr_gnt;
  logic [LEN_WIDTH-1:0]  wr_len;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  wr_done;

  logic                  rd_req;
  logic                  rd_gnt;
  logic [LEN_WIDTH-1:0]  rd_len;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_done;

  modport master (
    output wr_req, wr_len, wr_addr, wr_data, wr_valid, wr_last,
    input  wr_gnt, wr_ready, wr_done,
    output rd_req, rd_len, rd_addr, rd_ready,
    input  rd_gnt, rd_data, rd_valid, rd_done
  );

  modport slave (
    input  wr_req, wr_len, wr_addr, wr_data, wr_valid, wr_last,
    output wr_gnt, wr_ready, wr_done,
    input  rd_req, rd_len, rd_addr, rd_ready,
    output rd_gnt, rd_data, rd_valid, rd_done
  );

endinterface

// File: rtl/mem_burst_resp_rd_fifo.sv
// Two-entry read return FIFO carrying data plus a last-beat tag. Push and pop in
// the same cycle are allowed; the caller guarantees no push while full.
module mem_burst_rd_fifo #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/mem_burst_resp.sv
// Memory-side burst responder: serves one read or write burst at a time against a
// single-port SRAM with 1-cycle read latency.
// Build option MEM_BURST_RR_ARB_EN: round-robin arbitration between the channels;
// without it, writes always win a contended grant.
module mem_burst_resp
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_burst_resp_if.slave       bus,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [MEM_AW-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  err_wr_last
);

  state_e                state_q;
  logic [MEM_AW-1:0]     addr_q;    // next SRAM address of the burst
  logic [LEN_WIDTH-1:0]  n_q;       // beats in the burst
  logic [LEN_WIDTH-1:0]  cnt_q;     // beats accepted (write) or reads issued (read)
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  err_q;

  logic                  wr_win;
  logic                  wr_start;
  logic                  rd_start;
  logic                  wr_beat;
  logic                  wr_is_last;
  logic                  rd_issue;
  logic                  issue_last;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [LEN_WIDTH-1:0]  wr_n;
  logic [LEN_WIDTH-1:0]  rd_n;

`ifdef MEM_BURST_RR_ARB_EN
  logic last_wr_q;  // 1: write won the last grant
  assign wr_win = bus.wr_req && (!bus.rd_req || !last_wr_q);
`else
  assign wr_win = bus.wr_req;
`endif

  // Grants are combinational and only offered in IDLE; gated by reset so all outputs
  // stay low while rst_n is asserted.
  assign bus.wr_gnt = rst_n && (state_q == StIdle) && wr_win;
  assign bus.rd_gnt = rst_n && (state_q == StIdle) && bus.rd_req && !wr_win;
  assign wr_start   = bus.wr_gnt;
  assign rd_start   = bus.rd_gnt;

  assign wr_n = LEN_WIDTH'(beats_from_len(32'(bus.wr_len), DATA_WIDTH));
  assign rd_n = LEN_WIDTH'(beats_from_len(32'(bus.rd_len), DATA_WIDTH));

  assign wr_beat    = (state_q == StWrData) && bus.wr_valid;
  assign wr_is_last = (cnt_q == n_q - LEN_WIDTH'(1));

  // A pop in this cycle frees a slot, so it may be reused by this cycle's issue;
  // that keeps back-to-back beats flowing with rd_ready held high.
  assign fifo_pop   = (fifo_count != 2'd0) && bus.rd_ready;
  assign occ        = fifo_count + {1'b0, inflight_q};
  assign rd_issue   = (state_q == StRdData) && (cnt_q < n_q) &&
                      ((occ < 2'(FIFO_DEPTH)) || fifo_pop);
  // The first read goes out in the grant cycle itself.
  assign issue_last = rd_start ? (rd_n == LEN_WIDTH'(1)) : wr_is_last;

  assign sram_en    = wr_beat || rd_issue || rd_start;
  assign sram_we    = wr_beat;
  assign sram_addr  = rd_start ? bus.rd_addr[MEM_AW-1:0] : addr_q;
  assign sram_wdata = wr_beat ? bus.wr_data : '0;

  assign bus.wr_ready = (state_q == StWrData);
  assign bus.wr_done  = (state_q == StWrResp);
  assign bus.rd_valid = (fifo_count != 2'd0);
  assign bus.rd_data  = head_data;
  assign bus.rd_done  = bus.rd_valid && head_last;
  assign err_wr_last  = err_q;

  // Upper address bits are ignored; memory wraps modulo its depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.wr_addr[ADDR_WIDTH-1:MEM_AW], bus.rd_addr[ADDR_WIDTH-1:MEM_AW]};

  // Burst FSM with its address/beat counters and the sticky wr_last error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      n_q             <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
`ifdef MEM_BURST_RR_ARB_EN
      last_wr_q       <= 1'b0;
`endif
    end else begin
      inflight_q      <= rd_start || rd_issue;
      inflight_last_q <= issue_last;
      case (state_q)
        StIdle: begin
          if (wr_start) begin
            addr_q  <= bus.wr_addr[MEM_AW-1:0];
            n_q     <= wr_n;
            cnt_q   <= '0;
            state_q <= StWrData;
          end else if (rd_start) begin
            addr_q  <= bus.rd_addr[MEM_AW-1:0] + MEM_AW'(1);
            n_q     <= rd_n;
            cnt_q   <= LEN_WIDTH'(1);
            state_q <= StRdData;
          end
`ifdef MEM_BURST_RR_ARB_EN
          if (wr_start) begin
            last_wr_q <= 1'b1;
          end else if (rd_start) begin
            last_wr_q <= 1'b0;
          end
`endif
        end
        StWrData: begin
          if (wr_beat) begin
            addr_q <= addr_q + MEM_AW'(1);
            cnt_q  <= cnt_q + LEN_WIDTH'(1);
            if (bus.wr_last != wr_is_last) begin
              err_q <= 1'b1;
            end
            if (wr_is_last) begin
              state_q <= StWrResp;
            end
          end
        end
        StWrResp: begin
          state_q <= StIdle;
        end
        StRdData: begin
          if (rd_issue) begin
            addr_q <= addr_q + MEM_AW'(1);
            cnt_q  <= cnt_q + LEN_WIDTH'(1);
          end
          if (fifo_pop && head_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  mem_burst_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (sram_rdata),
    .push_last (inflight_last_q),
    .pop       (fifo_pop),
    .head_data (head_data),
    .head_last (head_last),
    .count     (fifo_count)
  );

endmodule
